puc_req_driver: RTL and testbench

PUC_REQ_DRIVER -- requirements
Module: puc_req_driver

---
 rtl/puc_pkg.sv | 25 ++
 rtl/puc_elem_counter.sv | 60 ++++++
 rtl/puc_req_driver.sv | 240 ++++++++++++++++++++++++
 tb/tb_puc_req_driver.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puc_pkg.sv
// puc_pkg: shared state encoding, dimension type and default geometry for the
// photonic request driver.
package puc_pkg;

  localparam int PUC_DWIDTH  = 16;
  localparam int PUC_MAX_ROW = 32;
  localparam int PUC_MAX_COL = 32;

  typedef logic [31:0] puc_dim_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD1,
    LOAD2,
    FIRE,
    WAIT,
    DRAIN
  } puc_state_e;

  // Element totals are widened so that 32-bit dimensions cannot overflow.
  function automatic logic [63:0] dim_prod(input puc_dim_t a, input puc_dim_t b);
    return {32'd0, a} * {32'd0, b};
  endfunction

endpackage

// File: rtl/puc_elem_counter.sv
// puc_elem_counter: row-major element walker (column first, wrap at cols) with
// terminal flags for the current and the following element.
module puc_elem_counter
  import puc_pkg::*;
(
  input  logic     clock_i,
  input  logic     reset_i,
  input  logic     clr_i,
  input  logic     adv_i,
  input  puc_dim_t rows_i,
  input  puc_dim_t cols_i,
  output puc_dim_t row_o,
  output puc_dim_t col_o,
  output puc_dim_t nxt_row_o,
  output puc_dim_t nxt_col_o,
  output logic     term_o,
  output logic     nxt_term_o
);

  puc_dim_t    row_q, col_q, cnt_q;
  puc_dim_t    row_d, col_d;
  logic [63:0] total;

  assign total = dim_prod(rows_i, cols_i);

  always_comb begin
    row_d = row_q;
    col_d = col_q + 32'd1;
    if (col_d >= cols_i) begin
      col_d = '0;
      row_d = row_q + 32'd1;
    end
  end

  // >= rather than == so a degenerate zero-size matrix still terminates.
  assign term_o     = ({32'd0, cnt_q} + 64'd1) >= total;
  assign nxt_term_o = ({32'd0, cnt_q} + 64'd2) >= total;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else if (adv_i) begin
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign row_o     = row_q;
  assign col_o     = col_q;
  assign nxt_row_o = row_d;
  assign nxt_col_o = col_d;

endmodule

// File: rtl/puc_req_driver.sv
// puc_req_driver: loads two operand matrices into packed buses, strobes the
// photonic adapter, then streams the result out. PUC_DRV_DIM_CHECK_EN adds start-time dimension checking.
module puc_req_driver
  import puc_pkg::*;
#(
  parameter int DWIDTH   = PUC_DWIDTH,
  parameter int MAX_ROW  = PUC_MAX_ROW,
  parameter int MAX_COL  = PUC_MAX_COL,
  parameter int RESP_LAT = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [31:0]                      in1_rows,
  input  logic [31:0]                      in1_cols,
  input  logic [31:0]                      in2_rows,
  input  logic [31:0]                      in2_cols,
  input  logic [31:0]                      out_rows,
  input  logic [31:0]                      out_cols,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DWIDTH-1:0]                s_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DWIDTH-1:0]                m_data,
  output logic                             m_last,
  output logic                             ena,
  output logic [31:0]                      d_in1_rows,
  output logic [31:0]                      d_in1_cols,
  output logic [31:0]                      d_in2_rows,
  output logic [31:0]                      d_in2_cols,
  output logic [31:0]                      d_out_rows,
  output logic [31:0]                      d_out_cols,
  output logic [MAX_ROW*MAX_COL*DWIDTH-1:0] ivalue_1,
  output logic [MAX_ROW*MAX_COL*DWIDTH-1:0] ivalue_2,
  input  logic [MAX_ROW*MAX_COL*DWIDTH-1:0] ovalue,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  // state | meaning
  // IDLE  | waiting for start
  // LOAD1 | accepting operand 1 elements
  // LOAD2 | accepting operand 2 elements
  // FIRE  | single-cycle ena to the adapter
  // WAIT  | RESP_LAT cycles for ovalue to settle
  // DRAIN | streaming result elements out

  localparam int BUS_W = MAX_ROW * MAX_COL * DWIDTH;
  localparam int OFF_W = $clog2(BUS_W);

  puc_state_e  state_q;
  logic        s_ready_q, m_valid_q, m_last_q, ena_q, busy_q, done_q, err_q;
  logic [DWIDTH-1:0] m_data_q;
  puc_dim_t    d_in1_rows_q, d_in1_cols_q, d_in2_rows_q, d_in2_cols_q;
  puc_dim_t    d_out_rows_q, d_out_cols_q;
  logic [BUS_W-1:0] ivalue_1_q, ivalue_2_q;
  logic [31:0] wait_q;

  logic        cnt_clr, cnt_adv, cnt_term, cnt_nxt_term;
  puc_dim_t    cnt_rows, cnt_cols, cnt_row, cnt_col, cnt_nxt_row, cnt_nxt_col;
  logic [OFF_W-1:0] wr_off, rd_off;
  logic        beat, dims_bad;

  assign beat = s_valid & s_ready_q;

`ifdef PUC_DRV_DIM_CHECK_EN
  assign dims_bad = (in1_rows == '0) || (in1_cols == '0) || (in2_rows == '0) ||
                    (in2_cols == '0) || (out_rows == '0) || (out_cols == '0) ||
                    (in1_rows > 32'(MAX_ROW)) || (in2_rows > 32'(MAX_ROW)) ||
                    (out_rows > 32'(MAX_ROW)) || (in1_cols > 32'(MAX_COL)) ||
                    (in2_cols > 32'(MAX_COL)) || (out_cols > 32'(MAX_COL));
`else
  assign dims_bad = 1'b0;
`endif

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_adv  = 1'b0;
    cnt_rows = d_in1_rows_q;
    cnt_cols = d_in1_cols_q;
    case (state_q)
      IDLE:  cnt_clr = 1'b1;
      LOAD1: begin
        cnt_adv = beat;
        cnt_clr = beat & cnt_term;
      end
      LOAD2: begin
        cnt_rows = d_in2_rows_q;
        cnt_cols = d_in2_cols_q;
        cnt_adv  = beat;
      end
      FIRE, WAIT: begin
        cnt_rows = d_out_rows_q;
        cnt_cols = d_out_cols_q;
        cnt_clr  = 1'b1;
      end
      DRAIN: begin
        cnt_rows = d_out_rows_q;
        cnt_cols = d_out_cols_q;
        cnt_adv  = m_valid_q & m_ready & ~cnt_term;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  puc_elem_counter u_cnt (
    .clock_i    (clock),
    .reset_i    (reset),
    .clr_i      (cnt_clr),
    .adv_i      (cnt_adv),
    .rows_i     (cnt_rows),
    .cols_i     (cnt_cols),
    .row_o      (cnt_row),
    .col_o      (cnt_col),
    .nxt_row_o  (cnt_nxt_row),
    .nxt_col_o  (cnt_nxt_col),
    .term_o     (cnt_term),
    .nxt_term_o (cnt_nxt_term)
  );

  assign wr_off = OFF_W'((cnt_row * 32'(MAX_COL) + cnt_col) * 32'(DWIDTH));
  assign rd_off = OFF_W'((cnt_nxt_row * 32'(MAX_COL) + cnt_nxt_col) * 32'(DWIDTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
      ena_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      d_in1_rows_q <= '0;
      d_in1_cols_q <= '0;
      d_in2_rows_q <= '0;
      d_in2_cols_q <= '0;
      d_out_rows_q <= '0;
      d_out_cols_q <= '0;
      ivalue_1_q   <= '0;
      ivalue_2_q   <= '0;
      wait_q       <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && dims_bad) begin
            err_q <= 1'b1;
          end else if (start) begin
            d_in1_rows_q <= in1_rows;
            d_in1_cols_q <= in1_cols;
            d_in2_rows_q <= in2_rows;
            d_in2_cols_q <= in2_cols;
            d_out_rows_q <= out_rows;
            d_out_cols_q <= out_cols;
            ivalue_1_q   <= '0;
            ivalue_2_q   <= '0;
            s_ready_q    <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= LOAD1;
          end
        end
        LOAD1: begin
          if (beat) begin
            ivalue_1_q[wr_off +: DWIDTH] <= s_data;
            if (cnt_term) state_q <= LOAD2;
          end
        end
        LOAD2: begin
          if (beat) begin
            ivalue_2_q[wr_off +: DWIDTH] <= s_data;
            if (cnt_term) begin
              s_ready_q <= 1'b0;
              ena_q     <= 1'b1;
              state_q   <= FIRE;
            end
          end
        end
        FIRE: begin
          ena_q   <= 1'b0;
          wait_q  <= 32'(RESP_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_q == '0) begin
            m_valid_q <= 1'b1;
            m_data_q  <= ovalue[DWIDTH-1:0];
            m_last_q  <= cnt_term;
            state_q   <= DRAIN;
          end else begin
            wait_q <= wait_q - 32'd1;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (m_last_q) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              m_data_q  <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              m_data_q <= ovalue[rd_off +: DWIDTH];
              m_last_q <= cnt_nxt_term;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign ena        = ena_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign d_in1_rows = d_in1_rows_q;
  assign d_in1_cols = d_in1_cols_q;
  assign d_in2_rows = d_in2_rows_q;
  assign d_in2_cols = d_in2_cols_q;
  assign d_out_rows = d_out_rows_q;
  assign d_out_cols = d_out_cols_q;
  assign ivalue_1   = ivalue_1_q;
  assign ivalue_2   = ivalue_2_q;

`ifdef PUC_DRV_DIM_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_puc_req_driver.sv
// tb_puc_req_driver: randomized operations against a matrix-level reference,
// with expected fires and result elements queued and checked by a monitor.
module tb_puc_req_driver;

  localparam int DW = 16;
  localparam int MR = 32;
  localparam int MC = 32;
  localparam int RL = 1;
  localparam int BW = MR * MC * DW;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [31:0] in1_rows = '0, in1_cols = '0, in2_rows = '0, in2_cols = '0;
  logic [31:0] out_rows = '0, out_cols = '0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [DW-1:0] s_data = '0;
  logic m_valid, m_last;
  logic m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic ena, busy, done, err;
  logic [31:0] d_in1_rows, d_in1_cols, d_in2_rows, d_in2_cols, d_out_rows, d_out_cols;
  logic [BW-1:0] ivalue_1, ivalue_2;
  logic [BW-1:0] ovalue = '0;

  always #5 clock = ~clock;

  puc_req_driver #(.DWIDTH(DW), .MAX_ROW(MR), .MAX_COL(MC), .RESP_LAT(RL)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in1_rows(in1_rows), .in1_cols(in1_cols), .in2_rows(in2_rows),
    .in2_cols(in2_cols), .out_rows(out_rows), .out_cols(out_cols),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .ena(ena),
    .d_in1_rows(d_in1_rows), .d_in1_cols(d_in1_cols), .d_in2_rows(d_in2_rows),
    .d_in2_cols(d_in2_cols), .d_out_rows(d_out_rows), .d_out_cols(d_out_cols),
    .ivalue_1(ivalue_1), .ivalue_2(ivalue_2), .ovalue(ovalue),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [BW-1:0] iv1;
    logic [BW-1:0] iv2;
    logic [31:0]   r1, c1, r2, c2, ro, co;
  } fire_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } out_t;

  fire_t fire_q[$];
  out_t  exp_out_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, ena_cnt = 0, ena_cyc = 0, beats = 0, hs_cnt = 0;
  int mr_mode = 0, pat_i = 0;
  bit wait_valid = 0, prev_stall = 0, done_exp = 0;
  logic [DW-1:0] prev_data = '0;
  logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  fire_t mf;
  out_t  mo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_bus(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    int first;
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      first = -1;
      for (int e = 0; e < MR * MC; e++)
        if (first < 0 && act[e*DW +: DW] !== exp[e*DW +: DW]) first = e;
      $display("FAIL %s: element %0d got %0h expected %0h", nm, first,
               act[first*DW +: DW], exp[first*DW +: DW]);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none/bounded (t=%0t)", nm, $time);
  endtask

  always @(posedge clock) begin
    #1;
    case (mr_mode)
      1: m_ready = 1'($urandom_range(0, 1));
      2: begin
        if (m_valid) begin
          m_ready = pat[pat_i];
          pat_i   = (pat_i + 1) % 4;
        end else begin
          m_ready = 1'b1;
          pat_i   = 0;
        end
      end
      default: m_ready = 1'b1;
    endcase
  end

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      wait_valid = 0;
      prev_stall = 0;
      done_exp   = 0;
    end else begin
      if (done || done_exp) chk("done_pulse", done, done_exp);
      if (done_exp) chk("busy_after_done", busy, 0);
      done_exp = 0;
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (ena) begin
        ena_cnt++;
        ena_cyc    = cyc;
        wait_valid = 1;
        if (fire_q.size() == 0) fail_now("unexpected_ena");
        else begin
          mf = fire_q.pop_front();
          chk_bus("ivalue_1", ivalue_1, mf.iv1);
          chk_bus("ivalue_2", ivalue_2, mf.iv2);
          chk("d_in1_rows", d_in1_rows, mf.r1);
          chk("d_in1_cols", d_in1_cols, mf.c1);
          chk("d_in2_rows", d_in2_rows, mf.r2);
          chk("d_in2_cols", d_in2_cols, mf.c2);
          chk("d_out_rows", d_out_rows, mf.ro);
          chk("d_out_cols", d_out_cols, mf.co);
        end
      end
      if (m_valid && wait_valid) begin
        chk("ena_to_valid", 64'(cyc - ena_cyc), RL + 1);
        wait_valid = 0;
      end
      if (s_valid && s_ready) beats++;
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_out_q.size() == 0) fail_now("unexpected_output");
        else begin
          mo = exp_out_q.pop_front();
          chk("m_data", m_data, mo.data);
          chk("m_last", m_last, mo.last);
          if (mo.last) done_exp = 1;
        end
      end
    end
  end

  task automatic set_dims(input int r1, c1, r2, c2, ro, co);
    in1_rows = 32'(r1); in1_cols = 32'(c1);
    in2_rows = 32'(r2); in2_cols = 32'(c2);
    out_rows = 32'(ro); out_cols = 32'(co);
  endtask

  task automatic scramble_dims();
    set_dims(int'($urandom), int'($urandom), int'($urandom),
             int'($urandom), int'($urandom), int'($urandom));
  endtask

  task automatic feed(input logic [DW-1:0] vals[$], input bit inject);
    int t;
    bit ok;
    for (int k = 0; k < vals.size(); k++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clock); #1;
      end
      s_valid = 1'b1;
      s_data  = vals[k];
      if (inject && k == 1) begin
        start = 1'b1;
        scramble_dims();
      end
      t  = 0;
      ok = 0;
      while (!ok && t < 50) begin
        @(negedge clock);
        if (s_ready) ok = 1; else t++;
      end
      if (!ok) begin
        fail_now("s_ready_timeout");
        s_valid = 1'b0;
        start   = 1'b0;
        return;
      end
      @(posedge clock); #1;
      start = 1'b0;
    end
    s_valid = 1'b0;
  endtask

  task automatic run_op(input int r1, c1, r2, c2, ro, co, input int mode,
                        input bit inject, input bit seq);
    logic [BW-1:0] b1, b2;
    logic [DW-1:0] v1[$], v2[$], v;
    fire_t f;
    out_t  o;
    int ena0, beats0, hs0, t;
    mr_mode = mode;
    for (int e = 0; e < MR * MC; e++) ovalue[e*DW +: DW] = DW'($urandom);
    b1 = '0;
    b2 = '0;
    for (int k = 0; k < r1 * c1; k++) begin
      v = seq ? DW'(k + 1) : DW'($urandom);
      b1[((k / c1) * MC + k % c1) * DW +: DW] = v;
      v1.push_back(v);
    end
    for (int k = 0; k < r2 * c2; k++) begin
      v = seq ? DW'(r1 * c1 + k + 1) : DW'($urandom);
      b2[((k / c2) * MC + k % c2) * DW +: DW] = v;
      v2.push_back(v);
    end
    f.iv1 = b1; f.iv2 = b2;
    f.r1 = 32'(r1); f.c1 = 32'(c1); f.r2 = 32'(r2);
    f.c2 = 32'(c2); f.ro = 32'(ro); f.co = 32'(co);
    fire_q.push_back(f);
    for (int k = 0; k < ro * co; k++) begin
      o.data = ovalue[((k / co) * MC + k % co) * DW +: DW];
      o.last = (k == ro * co - 1);
      exp_out_q.push_back(o);
    end
    ena0 = ena_cnt; beats0 = beats; hs0 = hs_cnt;
    @(posedge clock); #1;
    set_dims(r1, c1, r2, c2, ro, co);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    scramble_dims();
    feed(v1, 1'b0);
    feed(v2, inject);
    t = 0;
    while (!done && t < ro * co * 8 + 100) begin
      @(negedge clock);
      t++;
    end
    if (!done) begin
      fail_now("done_timeout");
      fire_q.delete();
      exp_out_q.delete();
    end
    @(negedge clock);
    chk("ena_count", 64'(ena_cnt - ena0), 1);
    chk("beat_count", 64'(beats - beats0), 64'(r1 * c1 + r2 * c2));
    chk("out_count", 64'(hs_cnt - hs0), 64'(ro * co));
    mr_mode = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_ena"}, ena, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_d_in1_rows"}, d_in1_rows, 0);
    chk({tag, "_d_out_cols"}, d_out_cols, 0);
    chk_bus({tag, "_ivalue_1"}, ivalue_1, '0);
    chk_bus({tag, "_ivalue_2"}, ivalue_2, '0);
  endtask

`ifdef PUC_DRV_DIM_CHECK_EN
  task automatic dim_reject(input int r1, c1, r2, c2, ro, co);
    int ena0;
    ena0 = ena_cnt;
    @(posedge clock); #1;
    set_dims(r1, c1, r2, c2, ro, co);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("dim_err_pulse", err, 1);
    chk("dim_s_ready", s_ready, 0);
    chk("dim_busy", busy, 0);
    @(posedge clock); #1;
    chk("dim_err_clear", err, 0);
    chk("dim_s_ready_after", s_ready, 0);
    repeat (4) @(posedge clock);
    #1;
    chk("dim_no_ena", 64'(ena_cnt - ena0), 0);
  endtask
`endif

  initial begin
    logic [DW-1:0] part[$];
    #1 reset = 1'b1;
    #3;
    check_reset_values("por");
    @(posedge clock); #1;
    reset = 1'b0;

    run_op(2, 2, 2, 2, 2, 2, 0, 1'b0, 1'b1);
    run_op(1, 1, 1, 1, 1, 3, 2, 1'b0, 1'b0);
    run_op(2, 2, 2, 2, 2, 2, 0, 1'b1, 1'b0);
    for (int n = 0; n < 6; n++)
      run_op($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
             $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
             1, 1'b0, 1'b0);
    run_op(32, 32, 32, 32, 2, 3, 1, 1'b0, 1'b0);

    // Abort a 2x2 load after three beats with an asynchronous reset.
    @(posedge clock); #1;
    set_dims(2, 2, 1, 1, 1, 1);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) part.push_back(DW'(16'h1000 + k));
    feed(part, 1'b0);
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_s_ready", s_ready, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_values("mid_load");
    @(posedge clock); #1;
    reset = 1'b0;
    run_op(1, 1, 1, 1, 1, 1, 0, 1'b0, 1'b0);

`ifdef PUC_DRV_DIM_CHECK_EN
    dim_reject(0, 2, 2, 2, 2, 2);
    dim_reject(2, 2, 2, 2, 2, 33);
`else
    chk("err_tied_low", err, 0);
`endif

    repeat (3) @(posedge clock);
    chk("queues_empty", 64'(fire_q.size() + exp_out_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
